// File: rtl/ip_sram_responder.sv
// ip_sram_responder
// -----------------
// Responder end of the mapper RAM interface. An initiator raises rd or wr
// while busy=0. The request turns into one timed access on an external
// asynchronous 8-bit SRAM with a 22-bit (4 MB) address space. Read data
// comes back on rdata, marked by a one-cycle rdata_en strobe.
//
// Handshake (valid/ready): rd/wr are requests and busy=0 is "ready". A
// request is taken at a rising edge where busy=0 and rd|wr. The address
// (and wdata) are captured at that edge. Requests seen while busy=1 are
// dropped, not queued. rd and wr together are treated as a read.
//
// Timing, with the request accepted at edge N:
//   read  : n_ce/n_oe are low for ACCESS_CYCLES cycles after edge N.
//           sram_din is latched at edge N+ACCESS_CYCLES, and rdata_en is
//           high for the cycle that follows that edge.
//   write : n_ce/n_we are low and the pad is driven for ACCESS_CYCLES
//           cycles. n_we then rises, and address/data/dout_en are held
//           for one more cycle.
//   Both are followed by RECOVER_CYCLES cycles with every strobe high.
//   busy falls at the edge that re-enters IDLE.
//
// Parameters:
//   ACCESS_CYCLES  (1..15) strobe-low cycles per access
//   RECOVER_CYCLES (0..3)  all-strobes-high cycles after each access
//
// Optional feature, macro IP_SRAM_RESPONDER_READ_CACHE_EN:
//   Adds a one-entry read cache (valid, 22-bit tag, 8-bit data). A read
//   hit returns the cached byte with rdata_en in the first cycle after
//   acceptance, without touching the SRAM and without raising busy.
//
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   rd, wr, address, wdata  request side
//   busy, rdata, rdata_en   response side
//   sram_*                  board SRAM pins (address, strobes, data pad)
//   dbg_state               current FSM state (IDLE/READ/WRITE/RECOVER)

module ip_sram_responder #(
    parameter int ACCESS_CYCLES  = 3,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rd,
    input  logic        wr,
    output logic        busy,
    input  logic [21:0] address,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_en,
    output logic [21:0] sram_address,
    output logic        sram_n_ce,
    output logic        sram_n_oe,
    output logic        sram_n_we,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_en,
    input  logic [7:0]  sram_din,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] REC_LOAD = 4'((RECOVER_CYCLES > 0) ? (RECOVER_CYCLES - 1) : 0);

    state_e      state_q;
    logic [3:0]  count_q;
    logic        hold_q;      // write is in its n_we-high data hold cycle
    logic        busy_q;
    logic [7:0]  rdata_q;
    logic        rdata_en_q;
    logic [21:0] addr_q;
    logic        n_ce_q;
    logic        n_oe_q;
    logic        n_we_q;
    logic [7:0]  dout_q;
    logic        dout_en_q;

    logic        cache_hit;
    logic [7:0]  cache_rdata;

`ifdef IP_SRAM_RESPONDER_READ_CACHE_EN
    logic        cache_valid_q;
    logic [21:0] cache_tag_q;
    logic [7:0]  cache_data_q;

    assign cache_hit   = cache_valid_q && (cache_tag_q == address);
    assign cache_rdata = cache_data_q;

    // Fill on the completing edge of a read miss. A write to the tagged
    // address refreshes the data so that a later hit never returns stale
    // contents.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= 22'd0;
            cache_data_q  <= 8'h00;
        end else begin
            if (state_q == ST_READ && count_q == 4'd0) begin
                cache_valid_q <= 1'b1;
                cache_tag_q   <= addr_q;
                cache_data_q  <= sram_din;
            end else if (state_q == ST_IDLE && wr && !rd && cache_hit) begin
                cache_data_q  <= wdata;
            end
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = 8'h00;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 4'd0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= 8'h00;
            rdata_en_q <= 1'b0;
            addr_q     <= 22'd0;
            n_ce_q     <= 1'b1;
            n_oe_q     <= 1'b1;
            n_we_q     <= 1'b1;
            dout_q     <= 8'h00;
            dout_en_q  <= 1'b0;
        end else begin
            rdata_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // busy is always low in IDLE, so reaching here is acceptance.
                    if (rd) begin
                        if (cache_hit) begin
                            rdata_q    <= cache_rdata;
                            rdata_en_q <= 1'b1;
                        end else begin
                            state_q   <= ST_READ;
                            busy_q    <= 1'b1;
                            count_q   <= ACC_LOAD;
                            addr_q    <= address;
                            n_ce_q    <= 1'b0;
                            n_oe_q    <= 1'b0;
                            dout_en_q <= 1'b0;
                        end
                    end else if (wr) begin
                        state_q   <= ST_WRITE;
                        busy_q    <= 1'b1;
                        count_q   <= ACC_LOAD;
                        hold_q    <= 1'b0;
                        addr_q    <= address;
                        dout_q    <= wdata;
                        n_ce_q    <= 1'b0;
                        n_we_q    <= 1'b0;
                        dout_en_q <= 1'b1;
                    end
                end

                ST_READ: begin
                    if (count_q == 4'd0) begin
                        rdata_q    <= sram_din;
                        rdata_en_q <= 1'b1;
                        n_ce_q     <= 1'b1;
                        n_oe_q     <= 1'b1;
                        if (RECOVER_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RECOVER;
                            count_q <= REC_LOAD;
                        end
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end

                ST_WRITE: begin
                    if (!hold_q) begin
                        if (count_q == 4'd0) begin
                            n_we_q <= 1'b1;
                            hold_q <= 1'b1;
                        end else begin
                            count_q <= count_q - 4'd1;
                        end
                    end else begin
                        hold_q    <= 1'b0;
                        n_ce_q    <= 1'b1;
                        dout_en_q <= 1'b0;
                        if (RECOVER_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RECOVER;
                            count_q <= REC_LOAD;
                        end
                    end
                end

                ST_RECOVER: begin
                    if (count_q == 4'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign rdata        = rdata_q;
    assign rdata_en     = rdata_en_q;
    assign sram_address = addr_q;
    assign sram_n_ce    = n_ce_q;
    assign sram_n_oe    = n_oe_q;
    assign sram_n_we    = n_we_q;
    assign sram_dout    = dout_q;
    assign sram_dout_en = dout_en_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ip_sram_responder.sv
// Testbench for ip_sram_responder.
// The bench contains a behavioural SRAM, a reference memory and a one-entry
// cache model. Each transaction is checked for strobe counts, latency,
// busy release and read data. Read data goes through a scoreboard queue.

module tb_ip_sram_responder;

    localparam int AC = 3;
    localparam int RC = 1;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [21:0] address = 22'd0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  sram_din = 8'h00;
    logic        busy;
    logic [7:0]  rdata;
    logic        rdata_en;
    logic [21:0] sram_address;
    logic        sram_n_ce;
    logic        sram_n_oe;
    logic        sram_n_we;
    logic [7:0]  sram_dout;
    logic        sram_dout_en;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  sram_mem [logic [21:0]];
    logic [7:0]  ref_mem [logic [21:0]];
    logic [21:0] pool [8];
`ifdef IP_SRAM_RESPONDER_READ_CACHE_EN
    bit          cache_v = 1'b0;
    logic [21:0] cache_tag = 22'd0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ip_sram_responder #(.ACCESS_CYCLES(AC), .RECOVER_CYCLES(RC)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .rd           (rd),
        .wr           (wr),
        .busy         (busy),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .rdata_en     (rdata_en),
        .sram_address (sram_address),
        .sram_n_ce    (sram_n_ce),
        .sram_n_oe    (sram_n_oe),
        .sram_n_we    (sram_n_we),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_din     (sram_din),
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hC3;
    endfunction

    function automatic logic [7:0] ref_read(input logic [21:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [7:0] sram_peek(input logic [21:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
    endfunction

    // Behavioural SRAM: stores while n_we is low and drives read data while
    // n_oe is low. Otherwise the bus carries junk.
    always @(negedge clk) begin
        if (!sram_n_ce && !sram_n_we) sram_mem[sram_address] = sram_dout;
        if (!sram_n_ce && !sram_n_oe) sram_din = sram_peek(sram_address);
        else sram_din = 8'($urandom);
    end

    // Pin protocol and read-data scoreboard
    always @(negedge clk) begin
        if (n_reset) begin
            check("strobe_excl", {31'd0, !sram_n_oe && !sram_n_we}, 32'd0);
            check("dout_en_vs_oe", {31'd0, sram_dout_en && !sram_n_oe}, 32'd0);
            if (rdata_en) begin
                if (exp_q.size() == 0) check("rdata_en_unexpected", 32'd1, 32'd0);
                else check("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", n < 100, 32'd1);
    endtask

    // Issue a request at the current negedge, then follow it until busy is
    // low again. Ends on a negedge with busy=0, so the next request can go
    // back to back.
    task automatic do_txn(input bit r, input bit w, input logic [21:0] a,
                          input logic [7:0] d, input bit poke);
        bit hit = 1'b0;
        int oe_n = 0, we_n = 0, den_n = 0, ren_n = 0, ren_at = 0, idle_at = 0;
        int addr_bad = 0, dout_bad = 0;
`ifdef IP_SRAM_RESPONDER_READ_CACHE_EN
        hit = r && cache_v && (cache_tag == a);
        if (r && !hit) begin
            cache_v = 1'b1;
            cache_tag = a;
        end
`endif
        if (r) exp_q.push_back(ref_read(a));
        else ref_mem[a] = d;
        rd = r; wr = w; address = a; wdata = d;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; address = 22'($urandom); wdata = 8'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!sram_n_oe) oe_n++;
            if (!sram_n_we) we_n++;
            if (sram_dout_en) begin
                den_n++;
                if (sram_dout !== d) dout_bad++;
            end
            if (!sram_n_ce && sram_address !== a) addr_bad++;
            if (rdata_en) begin
                ren_n++;
                ren_at = c;
            end
            if (c == 3) rd = 1'b0;
            if (poke && c == 2 && busy === 1'b1) begin
                rd = 1'b1;
                address = a ^ 22'h00_0001;
            end
            if (busy === 1'b0) begin
                idle_at = c;
                break;
            end
        end
        rd = 1'b0;
        check("sram_addr_held", addr_bad, 0);
        if (r) begin
            check("rd_oe_cycles", oe_n, hit ? 0 : AC);
            check("rd_we_cycles", we_n, 0);
            check("rd_dout_en", den_n, 0);
            check("rd_en_count", ren_n, 1);
            check("rd_en_latency", ren_at, hit ? 1 : AC + 1);
            check("rd_busy_release", idle_at, hit ? 1 : AC + RC + 1);
        end else begin
            check("wr_oe_cycles", oe_n, 0);
            check("wr_we_cycles", we_n, AC);
            check("wr_dout_en_cycles", den_n, AC + 1);
            check("wr_dout_value", dout_bad, 0);
            check("wr_no_rdata_en", ren_n, 0);
            check("wr_busy_release", idle_at, AC + RC + 2);
            check("wr_sram_content", {24'd0, sram_peek(a)}, {24'd0, d});
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_no_ce", {31'd0, sram_n_ce}, 32'd1);
            check("idle_no_rdata_en", {31'd0, rdata_en}, 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [21:0] a;
        int op;

        for (int i = 0; i < 8; i++) pool[i] = 22'($urandom);
        pool[0] = 22'h00_0010;

        // 1. reset with a request pending
        rd = 1'b1; wr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_rdata_en", {31'd0, rdata_en}, 32'd0);
            check("rst_strobes", {29'd0, sram_n_ce, sram_n_oe, sram_n_we}, 32'd7);
            check("rst_dout_en", {31'd0, sram_dout_en}, 32'd0);
            check("rst_rdata", {24'd0, rdata}, 32'd0);
            check("rst_sram_address", {10'd0, sram_address}, 32'd0);
            check("rst_state", {30'd0, dbg_state}, 32'd0);
        end
        rd = 1'b0; wr = 1'b0;
        n_reset = 1'b1;
        @(negedge clk);

        // 2. directed write
        do_txn(1'b0, 1'b1, 22'h12_3456, 8'hA5, 1'b0);

        // 3. directed read of a preloaded location
        sram_mem[22'h2A_4D00] = 8'h5A;
        ref_mem[22'h2A_4D00]  = 8'h5A;
        do_txn(1'b1, 1'b0, 22'h2A_4D00, 8'h00, 1'b0);
        check("t3_rdata_hold", {24'd0, rdata}, 32'h5A);

        // 4. a request while busy is dropped; rd+wr performs only the read
        do_txn(1'b1, 1'b0, 22'h01_2340, 8'h00, 1'b1);
        idle_check(4);
        do_txn(1'b1, 1'b1, 22'h0A_BCDE, 8'hEE, 1'b0);
        check("both_no_write", {24'd0, sram_peek(22'h0A_BCDE)}, {24'd0, init_val(22'h0A_BCDE)});

        // 5. reset during the second access cycle of a read
        wait_ready();
        rd = 1'b1; address = 22'h03_0303;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_oe_active", {31'd0, sram_n_oe}, 32'd0);
        #2;
        n_reset = 1'b0;
        #1;
        check("mid_rst_strobes", {29'd0, sram_n_ce, sram_n_oe, sram_n_we}, 32'd7);
        check("mid_rst_dout_en", {31'd0, sram_dout_en}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdata_en", {31'd0, rdata_en}, 32'd0);
        exp_q.delete();
`ifdef IP_SRAM_RESPONDER_READ_CACHE_EN
        cache_v = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        idle_check(6);
        do_txn(1'b1, 1'b0, 22'h03_0303, 8'h00, 1'b0);

`ifdef IP_SRAM_RESPONDER_READ_CACHE_EN
        // 6. read cache
        do_txn(1'b1, 1'b0, 22'h00_0010, 8'h00, 1'b0);
        do_txn(1'b1, 1'b0, 22'h00_0010, 8'h00, 1'b0);
        do_txn(1'b0, 1'b1, 22'h00_0010, 8'h77, 1'b0);
        do_txn(1'b1, 1'b0, 22'h00_0010, 8'h00, 1'b0);
        check("cache_hit_after_write", {24'd0, rdata}, 32'h77);
`endif

        // randomized traffic over a small address pool plus random addresses
        for (int t = 0; t < 80; t++) begin
            a  = ($urandom_range(0, 3) == 0) ? 22'($urandom) : pool[$urandom_range(0, 7)];
            op = $urandom_range(0, 9);
            if (op < 5)      do_txn(1'b1, 1'b0, a, 8'h00, $urandom_range(0, 4) == 0);
            else if (op < 9) do_txn(1'b0, 1'b1, a, 8'($urandom), $urandom_range(0, 4) == 0);
            else             do_txn(1'b1, 1'b1, a, 8'($urandom), 1'b0);
        end

        idle_check(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ip_sram_responder.md
Name: ip_sram_responder

Overview:
- Responder (target) end of the mapper RAM interface: accepts `rd`/`wr` requests, reports `busy`, and returns `rdata` with a one-cycle `rdata_en` strobe.
- Executes each request as a timed cycle on an external asynchronous 8-bit SRAM (4 MB address space).
- Sits between `ip_mapperram` (or any initiator using the same rd/wr/busy/rdata_en handshake) and the board SRAM pins.

Parameters:
- ACCESS_CYCLES, 3, cycles the SRAM strobe (n_oe or n_we) is held low per access; legal range 1..15.
- RECOVER_CYCLES, 1, cycles of all-strobes-high after each access before a new request is accepted; legal range 0..3.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous active-low reset.
- rd  input  1  read request, sampled only when busy=0.
- wr  input  1  write request, sampled only when busy=0.
- busy  output  1  1 = request on rd/wr this cycle is ignored.
- address  input  22  byte address, captured at acceptance.
- wdata  input  8  write data, captured at acceptance.
- rdata  output  8  read data, valid while rdata_en=1.
- rdata_en  output  1  one-cycle read-complete strobe.
- sram_address  output  22  SRAM address.
- sram_n_ce  output  1  SRAM chip enable, active low.
- sram_n_oe  output  1  SRAM output enable, active low.
- sram_n_we  output  1  SRAM write enable, active low.
- sram_dout  output  8  data driven to SRAM.
- sram_dout_en  output  1  1 = pad drives sram_dout.
- sram_din  input  8  data from SRAM.

Behaviour:
- Reset (async, n_reset=0), all outputs registered:
  - busy=0, rdata=0, rdata_en=0, sram_address=0
  - sram_n_ce=1, sram_n_oe=1, sram_n_we=1
  - sram_dout=0, sram_dout_en=0
  - state=IDLE, counter=0
- States: IDLE, READ, WRITE, RECOVER.
- Acceptance: at a posedge where state=IDLE and busy=0 and (rd|wr).
  - Capture address (and wdata for writes).
  - busy=1 from the next cycle.
  - Requests while busy=1 are dropped, not queued; the initiator must retry.
- Simultaneous rd=1 and wr=1: treated as read; the write is discarded.
- Read timing (accept at edge N):
  - From N+1 for ACCESS_CYCLES cycles: sram_address=captured address, n_ce=0, n_oe=0, dout_en=0.
  - At the edge ending the last access cycle, sram_din is latched into rdata and rdata_en=1 for exactly one cycle.
  - rdata_en rises at edge N+ACCESS_CYCLES+1.
  - Strobes go high in the same cycle; rdata holds its value until the next read completes.
- Write timing (accept at edge N):
  - From N+1 for ACCESS_CYCLES cycles: n_ce=0, n_we=0, dout_en=1, sram_dout=captured wdata.
  - Then n_we=1 with address, data and dout_en held for one extra cycle (hold time), then dout_en=0.
  - No rdata_en for writes.
- RECOVER: n_ce=1, n_oe=1, n_we=1 for RECOVER_CYCLES cycles.
  - busy falls at the edge entering IDLE.
  - RECOVER_CYCLES=0 skips the state.
- Back-to-back throughput:
  - Read: 1+ACCESS_CYCLES+RECOVER_CYCLES cycles per access.
  - Write: 2+ACCESS_CYCLES+RECOVER_CYCLES cycles per access.
- Strobe exclusivity: n_oe and n_we are never low together; dout_en=1 only while n_oe=1.
- Counter width: 4 bits; it loads ACCESS_CYCLES-1 and counts down to 0 (no wrap).
- Reset mid-operation: all strobes high and dout_en=0 immediately (asynchronous); any pending rdata_en is cancelled.

Optional Feature:
- Macro: IP_SRAM_RESPONDER_READ_CACHE_EN.
- When defined, a one-entry read cache is added (valid bit, 22-bit tag, 8-bit data).
  - Read hit at acceptance (valid and tag==address): no SRAM cycle, busy stays 0, rdata=cached data, rdata_en=1 at edge N+1.
  - Read miss: normal read, then the cache is filled.
  - Write to the tagged address updates the cached data.
  - Reset clears valid.
- When undefined: every read performs an SRAM cycle; no cache logic is synthesised.

Test Plan:
1. Reset: hold n_reset=0 with rd=1 -> busy=0, rdata_en=0, n_ce/n_oe/n_we=1, dout_en=0.
2. Write, ACCESS_CYCLES=3: address=22'h12_3456, wdata=8'hA5 -> n_we low exactly 3 cycles, sram_address=22'h12_3456, sram_dout=8'hA5, dout_en high 4 cycles, no rdata_en, busy low after recovery.
3. Read: sram_din model returns 8'h5A at 22'h2A_4D00 -> rdata_en single pulse 4 cycles after acceptance, rdata=8'h5A, n_oe low 3 cycles, n_we never low.
4. Busy and priority:
   - rd pulse while busy=1 -> ignored: no extra SRAM cycle, no rdata_en.
   - rd=1 and wr=1 together -> read cycle only, SRAM contents unchanged.
5. Reset mid-read: assert n_reset in the second access cycle -> strobes high immediately, no rdata_en after release, next read completes normally.
6. With IP_SRAM_RESPONDER_READ_CACHE_EN:
   - Read 22'h00_0010 twice -> second read gives rdata_en at N+1 and no n_oe activity.
   - Write 8'h77 to 22'h00_0010, then read -> cache hit returns 8'h77.
